// File: rtl/costas_loop_ctrl.sv
// Costas loop controller: integrate-and-dump of I/Q mixer signs over INT_LEN
// samples, a dead-band phase-step decision driving a 2-bit NCO offset, and a
// good-window counter that raises carrier lock.
//
// Ports:
//   clk, rst_n      - clock, async active-low reset (deassertion synchronised)
//   enable          - runs the loop; low in INTEGRATE aborts the window
//   sample_valid    - qualifies i_bit/q_bit
//   i_bit, q_bit    - mixer signs (1 = +1, 0 = -1)
//   phase_error     - modulo-4 phase offset to the NCO
//   dump_pulse      - one-cycle strobe at the end of each window
//   err_acc_out     - error accumulator snapshot, valid with dump_pulse
//   lock            - carrier-lock indicator
module costas_loop_ctrl #(
    parameter int unsigned INT_LEN  = 16,
    parameter int unsigned ERR_TH   = 4,
    parameter int unsigned LOCK_TH  = 12,
    parameter int unsigned LOCK_CNT = 4,
    localparam int unsigned ACC_W   = $clog2(INT_LEN) + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic                    i_bit,
    input  logic                    q_bit,
    output logic [1:0]              phase_error,
    output logic                    dump_pulse,
    output logic signed [ACC_W-1:0] err_acc_out,
    output logic                    lock
);

    localparam int unsigned CNT_W = $clog2(INT_LEN);
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [ACC_W-1:0] ERR_TH_P = ACC_W'(ERR_TH);
    localparam logic signed [ACC_W-1:0] ERR_TH_N = -ERR_TH_P;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        INTEGRATE = 2'b01,
        DUMP      = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic                    run_q;
    logic signed [ACC_W-1:0] err_acc_q, err_acc_d;
    logic signed [ACC_W-1:0] i_acc_q, i_acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LCK_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic                    dump_q, dump_d;
    logic signed [ACC_W-1:0] err_out_q, err_out_d;
    logic                    lock_q, lock_d;

    logic signed [ACC_W-1:0] err_step, i_step;
    logic [ACC_W-1:0]        i_abs;

    // +1 / -1 contributions of the current sample
    assign err_step = (i_bit ~^ q_bit) ? ACC_W'(1) : '1;
    assign i_step   = i_bit ? ACC_W'(1) : '1;
    assign i_abs    = i_acc_q[ACC_W-1] ? ACC_W'(-i_acc_q) : ACC_W'(i_acc_q);

    // Single-stage release flag: FSM may leave IDLE from the second edge on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_acc_q  <= '0;
            i_acc_q    <= '0;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            phase_q    <= 2'b00;
            dump_q     <= 1'b0;
            err_out_q  <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_acc_q  <= err_acc_d;
            i_acc_q    <= i_acc_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            phase_q    <= phase_d;
            dump_q     <= dump_d;
            err_out_q  <= err_out_d;
            lock_q     <= lock_d;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_d    = state_q;
        err_acc_d  = err_acc_q;
        i_acc_d    = i_acc_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        phase_d    = phase_q;
        err_out_d  = err_out_q;

        case (state_q)
            IDLE: begin
                err_acc_d = '0;
                i_acc_d   = '0;
                cnt_d     = '0;
                if (run_q && enable) state_d = INTEGRATE;
            end
            INTEGRATE: begin
                if (!enable) begin
                    // Abort: window and lock history are discarded
                    state_d    = IDLE;
                    err_acc_d  = '0;
                    i_acc_d    = '0;
                    cnt_d      = '0;
                    lock_cnt_d = '0;
                end else if (sample_valid) begin
                    err_acc_d = err_acc_q + err_step;
                    i_acc_d   = i_acc_q + i_step;
                    cnt_d     = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(INT_LEN - 1)) begin
                        state_d   = DUMP;
                        err_out_d = err_acc_q + err_step;
                    end
                end
            end
            DUMP: begin
                if (err_acc_q > ERR_TH_P)      phase_d = phase_q + 2'd1;
                else if (err_acc_q < ERR_TH_N) phase_d = phase_q - 2'd1;

                if (i_abs >= ACC_W'(LOCK_TH)) begin
                    if (lock_cnt_q != LCK_W'(LOCK_CNT)) lock_cnt_d = LCK_W'(lock_cnt_q + 1'b1);
                end else begin
                    lock_cnt_d = '0;
                end

                // A sample arriving during DUMP opens the next window
                if (sample_valid) begin
                    err_acc_d = err_step;
                    i_acc_d   = i_step;
                    cnt_d     = CNT_W'(1);
                end else begin
                    err_acc_d = '0;
                    i_acc_d   = '0;
                    cnt_d     = '0;
                end
                state_d = enable ? INTEGRATE : IDLE;
            end
            default: begin
                state_d   = IDLE;
                err_acc_d = '0;
                i_acc_d   = '0;
                cnt_d     = '0;
            end
        endcase

        dump_d = (state_d == DUMP);
        lock_d = (lock_cnt_d == LCK_W'(LOCK_CNT));
    end

    assign phase_error = phase_q;
    assign dump_pulse  = dump_q;
    assign err_acc_out = err_out_q;
    assign lock        = lock_q;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Directed bench for costas_loop_ctrl with default parameters
// (INT_LEN=16, ERR_TH=4, LOCK_TH=12, LOCK_CNT=4).
module tb_costas_loop_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              sample_valid;
    logic              i_bit;
    logic              q_bit;
    logic [1:0]        phase_error;
    logic              dump_pulse;
    logic signed [5:0] err_acc_out;
    logic              lock;

    int n_tests = 0;
    int n_fail  = 0;
    int dump_seen = 0;

    costas_loop_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .i_bit        (i_bit),
        .q_bit        (q_bit),
        .phase_error  (phase_error),
        .dump_pulse   (dump_pulse),
        .err_acc_out  (err_acc_out),
        .lock         (lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dump_pulse) dump_seen++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n samples (bit k of ip/qp is sample k), optional 3-cycle gap before
    // sample gap_at, then drive the DUMP-cycle sample and check results.
    task automatic window(input string tag, input int n,
                          input logic [15:0] ip, input logic [15:0] qp,
                          input int gap_at,
                          input logic d_sv, input logic d_i, input logic d_q,
                          input int exp_err, input int exp_phase, input int exp_lock);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                sample_valid = 1'b0;
                repeat (3) tick();
            end
            sample_valid = 1'b1;
            i_bit = ip[k];
            q_bit = qp[k];
            tick();
            if (k == n - 2) check_eq({tag, "_no_early_dump"}, int'(dump_pulse), 0);
        end
        check_eq({tag, "_dump"}, int'(dump_pulse), 1);
        check_eq({tag, "_err_acc"}, int'(err_acc_out), exp_err);
        sample_valid = d_sv;
        i_bit = d_i;
        q_bit = d_q;
        tick();
        sample_valid = 1'b0;
        check_eq({tag, "_dump_one_cycle"}, int'(dump_pulse), 0);
        check_eq({tag, "_phase"}, int'(phase_error), exp_phase);
        check_eq({tag, "_lock"}, int'(lock), exp_lock);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        enable = 1'b0;
        sample_valid = 1'b0;
        i_bit = 1'b0;
        q_bit = 1'b0;
        repeat (3) tick();
        check_eq("rst_phase", int'(phase_error), 0);
        check_eq("rst_lock", int'(lock), 0);
        check_eq("rst_dump", int'(dump_pulse), 0);
        check_eq("rst_err", int'(err_acc_out), 0);

        rst_n = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        // +16 -> phase 0->1; good window 1
        window("pos", 16, 16'hFFFF, 16'hFFFF, 99, 1'b0, 1'b0, 1'b0, 16, 1, 0);
        // -16 -> 1->0, then 0->3 (wrap); good windows 2, 3
        window("neg", 16, 16'hFFFF, 16'h0000, 99, 1'b0, 1'b0, 1'b0, -16, 0, 0);
        window("wrap", 16, 16'hFFFF, 16'h0000, 99, 1'b0, 1'b0, 1'b0, -16, 3, 0);
        // dead band, 4th good window -> lock rises
        window("dead", 16, 16'hFFFF, 16'h5555, 99, 1'b0, 1'b0, 1'b0, 0, 3, 1);
        // i alternating -> i_acc 0 -> lock falls; err +16 wraps 3->0
        window("unlock", 16, 16'h5555, 16'h5555, 99, 1'b0, 1'b0, 1'b0, 16, 0, 0);
        // sample during DUMP counts as sample 1 of the next window
        window("dsamp", 16, 16'hFFFF, 16'hFFFF, 99, 1'b1, 1'b1, 1'b1, 16, 1, 0);
        window("next", 15, 16'h7FFF, 16'h0000, 99, 1'b0, 1'b0, 1'b0, -14, 0, 0);

        // abort after 8 samples
        d0 = dump_seen;
        for (int k = 0; k < 8; k++) begin
            sample_valid = 1'b1;
            i_bit = 1'b1;
            q_bit = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check_eq("abort_no_dump", dump_seen - d0, 0);
        check_eq("abort_phase", int'(phase_error), 0);
        check_eq("abort_lock", int'(lock), 0);
        enable = 1'b1;
        tick();
        // 16 fresh samples with a gap inside
        window("reen", 16, 16'hFFFF, 16'hFFFF, 4, 1'b0, 1'b0, 1'b0, 16, 1, 0);

        // asynchronous reset mid-window
        for (int k = 0; k < 5; k++) begin
            sample_valid = 1'b1;
            i_bit = 1'b1;
            q_bit = 1'b0;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_phase", int'(phase_error), 0);
        check_eq("async_rst_lock", int'(lock), 0);
        check_eq("async_rst_dump", int'(dump_pulse), 0);
        sample_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        window("post_rst", 16, 16'hFFFF, 16'hFFFF, 99, 1'b0, 1'b0, 1'b0, 16, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
